// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the pushbutton step controller.
//   step_state_t : stepping FSM states
//   DIR_UP/DOWN  : UpDown encoding of the downstream up/down counter
//   cnt_width    : register width able to hold 0..n-1 (at least 1 bit)
//   max2         : larger of two integers, for sizing the shared timer
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } step_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizer plus debounce counter for one raw pushbutton.
//   clk   : system clock
//   reset : asynchronous, active-low
//   btn   : raw asynchronous button level
//   level : debounced button level
//   rise  : registered one-cycle strobe, high in the cycle after level goes 0->1
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          flip;

  assign differ = sync_b ^ level;
  // The counter has seen DB_CYCLES consecutive differing samples once it sits
  // at its last value and the current sample still differs.
  assign flip   = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      rise   <= flip && !level;
      if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/step_pulse_ctrl.sv
// Converts two bouncing pushbuttons into enable/UpDown steps for an up/down
// counter, with hold-to-repeat and a lockout while both buttons are pressed.
//   clk      : system clock
//   reset    : asynchronous, active-low
//   btn_up   : raw up button
//   btn_down : raw down button
//   enable   : one-cycle step strobe
//   UpDown   : step direction, 0 = up, 1 = down; changes only with enable
//   locked   : both buttons pressed / waiting for both to be released
//
// state  | meaning
// IDLE   | no button active; waiting for a fresh debounced press
// DELAY  | one button held; counting down to the first auto-repeat
// REPEAT | one button held; stepping every REPEAT_RATE cycles
// LOCK   | both buttons seen; no steps until both are released
module step_pulse_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic UpDown,
  output logic locked
);

  localparam int TW = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  logic          db_up;
  logic          db_down;
  logic          rise_up;
  logic          rise_down;
  step_state_t   state;
  step_state_t   state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          enable_nxt;
  logic          updown_nxt;
  logic          active_held;
  logic          other_held;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_up),
    .level (db_up),
    .rise  (rise_up)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_down),
    .level (db_down),
    .rise  (rise_down)
  );

  // UpDown remembers which button started the current hold.
  assign active_held = (UpDown == DIR_DOWN) ? db_down : db_up;
  assign other_held  = (UpDown == DIR_DOWN) ? db_up : db_down;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    enable_nxt = 1'b0;
    updown_nxt = UpDown;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (db_up && db_down) begin
          state_nxt = LOCK;
        end else if (rise_up) begin
          enable_nxt = 1'b1;
          updown_nxt = DIR_UP;
          state_nxt  = DELAY;
        end else if (rise_down) begin
          enable_nxt = 1'b1;
          updown_nxt = DIR_DOWN;
          state_nxt  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        // Exits outrank a due repeat pulse, so a step never coincides with lock/release.
        if (other_held) begin
          timer_nxt = '0;
          state_nxt = LOCK;
        end else if (!active_held) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else if (timer == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
          timer_nxt  = '0;
          enable_nxt = 1'b1;
          state_nxt  = REPEAT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      LOCK: begin
        timer_nxt = '0;
        if (!db_up && !db_down) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      enable <= 1'b0;
      UpDown <= DIR_UP;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      enable <= enable_nxt;
      UpDown <= updown_nxt;
      locked <= (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_step_pulse_ctrl.sv
module tb_step_pulse_ctrl;

  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RR   = 5;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic enable;
  logic UpDown;
  logic locked;

  always #5 clk = ~clk;

  step_pulse_ctrl #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .enable   (enable),
    .UpDown   (UpDown),
    .locked   (locked)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n0       = 0;
  int pulses[$];

  // Raw input history, indexed by the clock edge at which the level was present.
  bit raw_u[MAXC];
  bit raw_d[MAXC];
  int first_active = 1;

  // Reference model: debounced levels derived from a sliding window of the
  // synchronized samples; stepping tracked as "mode" plus the absolute edge
  // of the next scheduled repeat.
  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_LOCK = 2;
  bit m_du, m_dd, m_ru, m_rd, m_dir, e_en, e_lock;
  int mode;
  int next_at;

  // Synchronized value seen after edge j: raw level at edge j-1, or 0 if that
  // edge was held in reset.
  function automatic bit samp(input bit dn, input int j);
    if (j - 1 < first_active) return 1'b0;
    return dn ? raw_d[j-1] : raw_u[j-1];
  endfunction

  task automatic model_clear();
    m_du = 0; m_dd = 0; m_ru = 0; m_rd = 0; m_dir = 0;
    e_en = 0; e_lock = 0; mode = M_IDLE; next_at = 0;
  endtask

  task automatic model_edge(input int e);
    bit other, act, fu, fd;
    e_en = 0;
    case (mode)
      M_IDLE: begin
        if (m_du && m_dd) mode = M_LOCK;
        else if (m_ru) begin e_en = 1; m_dir = 0; mode = M_HOLD; next_at = e + RD; end
        else if (m_rd) begin e_en = 1; m_dir = 1; mode = M_HOLD; next_at = e + RD; end
      end
      M_HOLD: begin
        other = m_dir ? m_du : m_dd;
        act   = m_dir ? m_dd : m_du;
        if (other) mode = M_LOCK;
        else if (!act) mode = M_IDLE;
        else if (e == next_at) begin e_en = 1; next_at = e + RR; end
      end
      default: if (!m_du && !m_dd) mode = M_IDLE;
    endcase
    e_lock = (mode == M_LOCK);
    fu = 1; fd = 1;
    for (int k = 1; k <= DB; k++) begin
      if (samp(1'b0, e - k) == m_du) fu = 0;
      if (samp(1'b1, e - k) == m_dd) fd = 0;
    end
    m_ru = fu && !m_du;
    m_rd = fd && !m_dd;
    m_du = m_du ^ fu;
    m_dd = m_dd ^ fd;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    check_bit("enable", enable, e_en);
    check_bit("UpDown", UpDown, m_dir);
    check_bit("locked", locked, e_lock);
  endtask

  task automatic tick(input bit u, input bit d);
    btn_up   = u;
    btn_down = d;
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget edge=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    raw_u[cyc] = u;
    raw_d[cyc] = d;
    if (!reset) begin
      first_active = cyc + 1;
      model_clear();
    end else begin
      model_edge(cyc);
    end
    #1;
    check_outputs();
    if (enable === 1'b1) pulses.push_back(cyc);
  endtask

  task automatic reset_now();
    reset = 1'b0;
    model_clear();
    #1;
    check_bit("rst_enable", enable, 1'b0);
    check_bit("rst_UpDown", UpDown, 1'b0);
    check_bit("rst_locked", locked, 1'b0);
  endtask

  task automatic start_scn();
    n0 = cyc;
    pulses.delete();
  endtask

  function automatic int pulse_rel(input int i);
    if (i >= pulses.size()) return -1;
    return pulses[i] - n0;
  endfunction

  initial begin
    int exp_rep[7];
    bit u, d;
    int bouncy;
    exp_rep = '{7, 17, 22, 27, 32, 37, 42};

    btn_up = 0; btn_down = 0;
    model_clear();
    reset_now();
    repeat (3) tick(0, 0);
    reset = 1'b1;
    repeat (5) tick(0, 0);

    // Clean press
    start_scn();
    repeat (10) tick(1, 0);
    repeat (12) tick(0, 0);
    check_int("clean_count", pulses.size(), 1);
    check_int("clean_edge", pulse_rel(0), 7);
    check_bit("clean_dir", UpDown, 1'b0);

    // Bounce rejection
    start_scn();
    repeat (2) tick(0, 1);
    repeat (2) tick(0, 0);
    repeat (2) tick(0, 1);
    repeat (2) tick(0, 0);
    repeat (8) tick(0, 1);
    repeat (15) tick(0, 0);
    check_int("bounce_count", pulses.size(), 1);
    check_int("bounce_edge", pulse_rel(0), 15);
    check_bit("bounce_dir", UpDown, 1'b1);

    // Auto-repeat
    start_scn();
    repeat (40) tick(1, 0);
    repeat (20) tick(0, 0);
    check_int("repeat_count", pulses.size(), 7);
    for (int i = 0; i < 7; i++) check_int($sformatf("repeat_edge%0d", i), pulse_rel(i), exp_rep[i]);

    // Both buttons
    start_scn();
    repeat (7) tick(1, 0);
    repeat (6) tick(1, 1);
    check_bit("lock_pre", locked, 1'b0);
    tick(1, 1);
    check_bit("lock_on", locked, 1'b1);
    repeat (13) tick(1, 1);
    repeat (20) tick(1, 0);
    check_bit("lock_single_held", locked, 1'b1);
    repeat (15) tick(0, 0);
    check_bit("lock_released", locked, 1'b0);
    check_int("both_count", pulses.size(), 1);
    check_int("both_edge", pulse_rel(0), 7);

    // Reset mid-hold
    start_scn();
    repeat (20) tick(0, 1);
    check_bit("prerst_dir", UpDown, 1'b1);
    reset_now();
    repeat (5) tick(0, 1);
    reset = 1'b1;
    repeat (10) tick(0, 1);
    repeat (15) tick(0, 0);
    check_int("rst_count", pulses.size(), 3);
    check_int("rst_fresh_edge", pulse_rel(2), 32);

    // Direction hold
    start_scn();
    repeat (10) tick(1, 0);
    repeat (12) tick(0, 0);
    check_bit("dir_between", UpDown, 1'b0);
    repeat (6) tick(0, 1);
    check_bit("dir_before", UpDown, 1'b0);
    tick(0, 1);
    check_bit("dir_after", UpDown, 1'b1);
    check_bit("dir_pulse", enable, 1'b1);
    repeat (3) tick(0, 1);
    repeat (15) tick(0, 0);

    // Randomized buttons with occasional resets
    u = 0; d = 0; bouncy = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) bouncy = ($urandom_range(0, 2) == 0);
      if (!reset) begin
        if ($urandom_range(0, 1) == 0) reset = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        reset_now();
      end
      if ($urandom_range(0, bouncy ? 2 : 24) == 0) u = ~u;
      if ($urandom_range(0, bouncy ? 2 : 30) == 0) d = ~d;
      tick(u, d);
    end
    reset = 1'b1;
    repeat (30) tick(0, 0);
    check_bit("final_locked", locked, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
